// File: rtl/window_fetch.sv
// window_fetch: raster-scan 3x3 window reader feeding the median sorter.
// For each centre pixel it reads nine edge-clamped neighbours from a 1-cycle-latency RAM.
module window_fetch #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = 12,
    parameter int SIZE   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              ram_rd,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [SIZE-1:0]   ram_dout,
    output logic [9*SIZE-1:0] win,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state_dbg
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DRAIN   = 3'd2,
        PRESENT = 3'd3,
        FIN     = 3'd4
    } state_t;

    state_t         state;
    logic [XW-1:0]  x, nx;
    logic [YW-1:0]  y, ny;
    logic [3:0]     k;
    logic [SIZE-1:0] pix [9];
    logic           last_col, last_pix;

    // Address of neighbour kk around (cx, cy), with row/col clamped to the image.
    function automatic logic [ADDR_W-1:0] nb_addr(input logic [XW-1:0] cx,
                                                   input logic [YW-1:0] cy,
                                                   input logic [3:0]    kk);
        logic [1:0]    dr, dc;
        logic [XW-1:0] col;
        logic [YW-1:0] row;
        case (kk)
            4'd0:    {dr, dc} = 4'b0000;
            4'd1:    {dr, dc} = 4'b0001;
            4'd2:    {dr, dc} = 4'b0010;
            4'd3:    {dr, dc} = 4'b0100;
            4'd4:    {dr, dc} = 4'b0101;
            4'd5:    {dr, dc} = 4'b0110;
            4'd6:    {dr, dc} = 4'b1000;
            4'd7:    {dr, dc} = 4'b1001;
            4'd8:    {dr, dc} = 4'b1010;
            default: {dr, dc} = 4'b0101;
        endcase
        row = (dr == 2'd0) ? ((cy == '0) ? cy : cy - 1'b1)
            : (dr == 2'd2) ? ((cy == YW'(IMG_H - 1)) ? cy : cy + 1'b1)
            : cy;
        col = (dc == 2'd0) ? ((cx == '0) ? cx : cx - 1'b1)
            : (dc == 2'd2) ? ((cx == XW'(IMG_W - 1)) ? cx : cx + 1'b1)
            : cx;
        return ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);
    endfunction

    always_comb begin
        last_col = (x == XW'(IMG_W - 1));
        last_pix = last_col && (y == YW'(IMG_H - 1));
        nx       = last_col ? '0 : x + 1'b1;
        ny       = last_col ? y + 1'b1 : y;
    end

    // A window is offered while win_valid=1 and retired on the cycle win_valid && win_ready;
    // while it waits, win/out_addr stay frozen and no RAM reads are issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            k         <= '0;
            ram_rd    <= 1'b0;
            ram_addr  <= '0;
            win_valid <= 1'b0;
            out_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < 9; i++) pix[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FETCH;
                        x        <= '0;
                        y        <= '0;
                        k        <= '0;
                        ram_rd   <= 1'b1;
                        ram_addr <= nb_addr('0, '0, 4'd0);
                        busy     <= 1'b1;
                    end
                end
                FETCH: begin
                    // Data for read k-1 arrives now, one cycle behind its address.
                    if (k != 4'd0) pix[k - 4'd1] <= ram_dout;
                    if (k == 4'd8) begin
                        ram_rd <= 1'b0;
                        state  <= DRAIN;
                    end else begin
                        k        <= k + 4'd1;
                        ram_addr <= nb_addr(x, y, k + 4'd1);
                    end
                end
                DRAIN: begin
                    pix[8]    <= ram_dout;
                    out_addr  <= ADDR_W'(y) * ADDR_W'(IMG_W) + ADDR_W'(x);
                    win_valid <= 1'b1;
                    state     <= PRESENT;
                end
                PRESENT: begin
                    if (win_ready) begin
                        win_valid <= 1'b0;
                        if (last_pix) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            x        <= nx;
                            y        <= ny;
                            k        <= '0;
                            ram_rd   <= 1'b1;
                            ram_addr <= nb_addr(nx, ny, 4'd0);
                            state    <= FETCH;
                        end
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < 9; g++) begin : g_pack
        assign win[(8 - g) * SIZE +: SIZE] = pix[g];
    end

    assign state_dbg = state;
endmodule

// File: tb/tb_window_fetch.sv
// Bench for window_fetch on a 4x4 image: scoreboard of windows from a clamped-neighbour
// model, plus timing, backpressure, mid-frame reset and ignored-start scenarios.
module tb_window_fetch;
    localparam int IMG_W  = 4;
    localparam int IMG_H  = 4;
    localparam int ADDR_W = 4;
    localparam int SIZE   = 8;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int EW     = ADDR_W + 9 * SIZE;

    localparam logic [EW-1:0] W0  = {4'd0,  8'd0,  8'd0,  8'd1,  8'd0,  8'd0,  8'd1,  8'd4,  8'd4,  8'd5};
    localparam logic [EW-1:0] W5  = {4'd5,  8'd0,  8'd1,  8'd2,  8'd4,  8'd5,  8'd6,  8'd8,  8'd9,  8'd10};
    localparam logic [EW-1:0] W15 = {4'd15, 8'd10, 8'd11, 8'd11, 8'd14, 8'd15, 8'd15, 8'd14, 8'd15, 8'd15};

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, win_ready = 1'b0;
    logic ram_rd, win_valid, busy, done;
    logic [ADDR_W-1:0] ram_addr, out_addr;
    logic [SIZE-1:0]   ram_dout = '0;
    logic [9*SIZE-1:0] win;
    logic [2:0]        state_dbg;

    logic [SIZE-1:0] mem [NPIX];
    logic [EW-1:0]   exp_q[$];
    logic [EW-1:0]   first_win, saved_win0;
    bit              ident;
    int              checks = 0, errors = 0;

    window_fetch #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .SIZE(SIZE)) dut (
        .clk(clk), .rst(rst), .start(start),
        .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_dout(ram_dout),
        .win(win), .win_valid(win_valid), .win_ready(win_ready),
        .out_addr(out_addr), .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_rd) ram_dout <= mem[ram_addr];

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [EW-1:0] model_window(input int cx, input int cy);
        logic [9*SIZE-1:0] w;
        int r, c;
        w = '0;
        for (int n = 0; n < 9; n++) begin
            r = cy + n / 3 - 1;
            c = cx + n % 3 - 1;
            if (r < 0) r = 0;
            if (r > IMG_H - 1) r = IMG_H - 1;
            if (c < 0) c = 0;
            if (c > IMG_W - 1) c = IMG_W - 1;
            w = {w[8*SIZE-1:0], mem[r * IMG_W + c]};
        end
        return {ADDR_W'(cy * IMG_W + cx), w};
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_ram_rd"},    ram_rd,    0);
        check({tag, "_ram_addr"},  ram_addr,  0);
        check({tag, "_win"},       win,       0);
        check({tag, "_win_valid"}, win_valid, 0);
        check({tag, "_out_addr"},  out_addr,  0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_done"},      done,      0);
        check({tag, "_state"},     state_dbg, 0);
    endtask

    // mode 0: ready=1 with a stray start mid-frame; 1: 5-cycle stall at out_addr 2;
    // 2: random ready; 3: reset during the fetch of window 6.
    task automatic run_frame(input int mode);
        int cyc, dones, accepted, last_acc, hold;
        bit prev_valid, finished;
        logic [EW-1:0] snap, got;
        cyc = 0; dones = 0; accepted = 0; last_acc = 0; hold = 0;
        prev_valid = 0; finished = 0; snap = '0;
        exp_q.delete();
        for (int yy = 0; yy < IMG_H; yy++)
            for (int xx = 0; xx < IMG_W; xx++)
                exp_q.push_back(model_window(xx, yy));
        start = 1'b1;
        while (!finished && cyc < 3000) begin
            tick();
            cyc++;
            start = 1'b0;
            got = {out_addr, win};
            check("rd_while_valid", ram_rd && win_valid, 0);
            if (mode == 3 && accepted == 6 && cyc == last_acc + 3) begin
                check("rd_before_rst", ram_rd, 1);
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check_idle("mid_rst");
                for (int i = 0; i < 12; i++) begin
                    tick();
                    check("post_rst_quiet", {done, win_valid, busy, ram_rd}, 0);
                end
                finished = 1;
            end else if (done) begin
                dones++;
                check("done_after_acc", cyc, last_acc + 1);
                if (mode == 0) check("done_abs_cycle", cyc, 177);
                check("busy_in_fin", busy, 1);
                start = 1'b1;
                tick();
                start = 1'b0;
                check("idle_busy", busy, 0);
                check("idle_no_rd", ram_rd, 0);
                check("single_done", done, 0);
                finished = 1;
            end else begin
                if (win_valid && !prev_valid)
                    check("valid_rise_cycle", cyc, (accepted == 0) ? 11 : last_acc + 11);
                win_ready = 1'b1;
                if (mode == 0 && cyc == 50) start = 1'b1;
                if (mode == 2) win_ready = ($urandom_range(0, 3) != 0);
                if (mode == 1 && win_valid && out_addr == 2 && hold <= 5) begin
                    if (hold == 0) snap = got;
                    else check("stall_hold", {win_valid, got}, {1'b1, snap});
                    check("stall_no_rd", ram_rd, 0);
                    if (hold < 5) win_ready = 1'b0;
                    hold++;
                end
                if (win_valid && win_ready) begin
                    if (exp_q.size() == 0) check("extra_window", 1, 0);
                    else check("window", got, exp_q.pop_front());
                    if (ident && out_addr == 0)  check("win_corner0", got, W0);
                    if (ident && out_addr == 5)  check("win_center5", got, W5);
                    if (ident && out_addr == 15) check("win_corner15", got, W15);
                    if (accepted == 0) first_win = got;
                    accepted++;
                    last_acc = cyc;
                end
                prev_valid = win_valid;
            end
        end
        check("frame_finished", finished, 1);
        if (mode != 3) begin
            check("done_count", dones, 1);
            check("accepted", accepted, NPIX);
            check("queue_empty", exp_q.size(), 0);
        end
        if (mode == 1) check("stall_seen", hold, 6);
    endtask

    initial begin
        for (int a = 0; a < NPIX; a++) mem[a] = SIZE'(a);
        ident = 1;
        rst = 1'b1;
        repeat (3) tick();
        check_idle("reset");
        rst = 1'b0;
        tick();
        run_frame(0);
        run_frame(1);
        run_frame(3);
        saved_win0 = first_win;
        run_frame(0);
        check("restart_win0", first_win, saved_win0);
        ident = 0;
        repeat (3) begin
            for (int a = 0; a < NPIX; a++) mem[a] = SIZE'($urandom_range(0, 255));
            run_frame(2);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
